dm_port_arbiter: RTL and testbench

//   Shares the single-port M-stage data memory between the CPU (port 0) and an external debug/DMA bridge (port 1).
//   Per-cycle arbitration: CPU has priority, port 1 has a starvation guarantee.

---
 rtl/dm_pkg.sv | 33 +++
 rtl/dm_store_merge.sv | 13 +
 rtl/dm_port_arbiter.sv | 133 +++++++++++++
 tb/tb_dm_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory port arbiter and its lane-merge logic.
package dm_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NBYTES = XLEN / 8;

  localparam logic [NBYTES-1:0] BE_WORD = 4'b1111;

  typedef enum logic {
    PRI_CPU  = 1'b0,
    FORCE_M1 = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [NBYTES-1:0] be;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
  } dm_req_t;

  // Enabled lanes come from the store data, the rest from the current DM word.
  function automatic logic [XLEN-1:0] merge_lanes(input logic [NBYTES-1:0] be,
                                                  input logic [XLEN-1:0]   wdata,
                                                  input logic [XLEN-1:0]   rdata);
    logic [XLEN-1:0] word;
    word = rdata;
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (be[i]) word[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return word;
  endfunction

endpackage

// File: rtl/dm_store_merge.sv
// Combinational byte-lane merge of store data into the current DM word.
module dm_store_merge
  import dm_pkg::*;
(
  input  logic [NBYTES-1:0] be,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   merged_c
);

  assign merged_c = merge_lanes(be, wdata, rdata);

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port M-stage DM between the CPU (port 0, priority) and a debug/DMA
// bridge (port 1, starvation-bounded); sub-word stores become single-cycle RMW word writes.
module dm_port_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_pc,
  output logic [31:0] m0_rdata,
  output logic        m0_stall,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        err,
  output logic        dm_en,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

  localparam int unsigned CNT_W      = $clog2(STARVE_MAX + 1);
  localparam int unsigned ADDR_LIMIT = DEPTH_WORDS * 4;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             err_q, err_d;
  logic             m1_rvalid_q, m1_rvalid_d;
  logic [31:0]      m1_rdata_q, m1_rdata_d;

  logic             grant0, grant1, granted, in_range;
  logic [CNT_W-1:0] starve_inc;
  dm_req_t          m0_bus, m1_bus, sel;

  assign m0_bus     = '{we: m0_we, be: m0_be, addr: m0_addr, wdata: m0_wdata};
  assign m1_bus     = '{we: m1_we, be: m1_be, addr: m1_addr, wdata: m1_wdata};
  assign starve_inc = starve_cnt_q + CNT_W'(1);

  // Arbitration: grants are same-cycle; nothing is granted while reset is asserted.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    grant0       = 1'b0;
    grant1       = 1'b0;
    if (!reset) begin
      case (state_q)
        PRI_CPU: begin
          if (m0_req) begin
            grant0 = 1'b1;
            if (m1_req) begin
              starve_cnt_d = starve_inc;
              if (starve_inc == CNT_W'(STARVE_MAX - 1)) state_d = FORCE_M1;
            end
          end else if (m1_req) begin
            grant1 = 1'b1;
          end
        end
        FORCE_M1: begin
          grant1       = m1_req;
          grant0       = m0_req & ~m1_req;
          starve_cnt_d = '0;
          state_d      = PRI_CPU;
        end
        default: state_d = PRI_CPU;
      endcase
      if (grant1) starve_cnt_d = '0;
    end
  end

  // Datapath: selected port drives the DM; out-of-range accesses never write.
  always_comb begin
    sel = '0;
    if (grant1)      sel = m1_bus;
    else if (grant0) sel = m0_bus;
  end

  assign granted  = grant0 | grant1;
  assign in_range = (sel.addr < 32'(ADDR_LIMIT));
  assign dm_addr  = sel.addr;
  assign dm_en    = granted & sel.we & (|sel.be) & in_range;
  assign dm_pc    = grant0 ? m0_pc : 32'h0;
  assign m0_rdata = (grant0 & in_range) ? dm_rd : 32'h0;
  assign m0_stall = m0_req & ~grant0 & ~reset;
  assign m1_gnt   = grant1;

  dm_store_merge u_merge (
    .be       (sel.be),
    .wdata    (sel.wdata),
    .rdata    (dm_rd),
    .merged_c (dm_wd)
  );

  always_comb begin
    err_d       = granted & ~in_range;
    m1_rvalid_d = grant1 & ~m1_we;
    m1_rdata_d  = m1_rdata_q;
    if (m1_rvalid_d) m1_rdata_d = in_range ? dm_rd : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PRI_CPU;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      m1_rdata_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
      m1_rvalid_q  <= m1_rvalid_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign err       = err_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of arbitration, lane merge and range rules.
module tb_dm_port_arbiter;

  localparam int unsigned DEPTH_WORDS = 3072;
  localparam int unsigned STARVE_MAX  = 4;

  logic        clk, reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata, dm_addr, dm_wd, dm_pc, dm_rd;
  logic        m0_stall, m1_gnt, m1_rvalid, err, dm_en;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] dm_mem  [0:4095] = '{default: 32'h0};
  logic [31:0] ref_mem [0:4095] = '{default: 32'h0};

  dm_port_arbiter #(.DEPTH_WORDS(DEPTH_WORDS), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_pc(m0_pc), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .err(err), .dm_en(dm_en), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc), .dm_rd(dm_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port DM: combinational read, synchronous write.
  assign dm_rd = dm_mem[dm_addr[13:2]];
  always @(posedge clk) if (dm_en) dm_mem[dm_addr[13:2]] <= dm_wd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_be = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_pc = 32'h0;
    m1_req = 0; m1_we = 0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
  endtask

  task automatic drive_m0(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc);
    m0_req = 1; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata; m0_pc = pc;
  endtask

  task automatic drive_m1(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata);
    m1_req = 1; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
  endtask

  function automatic logic [31:0] lane_merge(input logic [3:0] be, input logic [31:0] wd,
                                             input logic [31:0] old);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (wd & mask) | (old & ~mask);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return 32'h3000 + 32'($urandom_range(0, 3)) * 4;
    if (r == 1) return 32'h0001_0100 + 32'($urandom_range(0, 7)) * 4;
    return 32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
  endfunction

  task automatic test_reset();
    reset = 1; idle();
    drive_m0(1, 4'hF, 32'h0, 32'h1234_5678, 32'h40);
    drive_m1(0, 4'hF, 32'h0, 32'h0);
    #2;
    tests_run++; if (m0_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_m0_stall got=%b exp=0", m0_stall); end
    tests_run++; if (m1_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_m1_gnt got=%b exp=0", m1_gnt); end
    tests_run++; if (dm_en !== 1'b0) begin tests_failed++; $display("FAIL reset_dm_en got=%b exp=0", dm_en); end
    tick();
    tests_run++; if (m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_m1_rvalid got=%b exp=0", m1_rvalid); end
    tests_run++; if (m1_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_m1_rdata got=%h exp=0", m1_rdata); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%b exp=0", err); end
    reset = 0; idle();
  endtask

  task automatic test_cpu_store();
    drive_m0(1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0000_0400);
    #2;
    tests_run++; if (dm_en !== 1'b1) begin tests_failed++; $display("FAIL sw_dm_en got=%b exp=1", dm_en); end
    tests_run++; if (dm_wd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL sw_dm_wd got=%h exp=deadbeef", dm_wd); end
    tests_run++; if (m0_stall !== 1'b0) begin tests_failed++; $display("FAIL sw_m0_stall got=%b exp=0", m0_stall); end
    tests_run++; if (dm_pc !== 32'h400) begin tests_failed++; $display("FAIL sw_dm_pc got=%h exp=400", dm_pc); end
    tests_run++; if (dm_addr !== 32'h10) begin tests_failed++; $display("FAIL sw_dm_addr got=%h exp=10", dm_addr); end
    tick(); idle();
  endtask

  task automatic test_byte_merge();
    drive_m0(1, 4'hF, 32'h20, 32'h1122_3344, 32'h404);
    tick();
    drive_m0(1, 4'b0100, 32'h22, 32'h00AA_0000, 32'h408);
    #2;
    tests_run++; if (dm_en !== 1'b1) begin tests_failed++; $display("FAIL sb_dm_en got=%b exp=1", dm_en); end
    tests_run++; if (dm_wd !== 32'h11AA_3344) begin tests_failed++; $display("FAIL sb_dm_wd got=%h exp=11aa3344", dm_wd); end
    tick();
    drive_m0(1, 4'b0000, 32'h20, 32'hFFFF_FFFF, 32'h40C);
    #2;
    tests_run++; if (dm_en !== 1'b0) begin tests_failed++; $display("FAIL be0_dm_en got=%b exp=0", dm_en); end
    tests_run++; if (m0_stall !== 1'b0) begin tests_failed++; $display("FAIL be0_m0_stall got=%b exp=0", m0_stall); end
    tick();
    drive_m0(0, 4'h0, 32'h20, 32'h0, 32'h410);
    #2;
    tests_run++; if (m0_rdata !== 32'h11AA_3344) begin tests_failed++; $display("FAIL lw_m0_rdata got=%h exp=11aa3344", m0_rdata); end
    tick(); idle();
  endtask

  task automatic test_starvation();
    for (int c = 1; c <= 5; c++) begin
      drive_m0(0, 4'h0, 32'h10, 32'h0, 32'h500 + 32'(c));
      if (c <= 4) drive_m1(0, 4'hF, 32'h10, 32'h0); else m1_req = 0;
      #2;
      tests_run++; if (m1_gnt !== (c == 4)) begin tests_failed++; $display("FAIL starve_m1_gnt cyc=%0d got=%b exp=%b", c, m1_gnt, (c == 4)); end
      tests_run++; if (m0_stall !== (c == 4)) begin tests_failed++; $display("FAIL starve_m0_stall cyc=%0d got=%b exp=%b", c, m0_stall, (c == 4)); end
      tick();
      tests_run++; if (m1_rvalid !== (c == 4)) begin tests_failed++; $display("FAIL starve_m1_rvalid cyc=%0d got=%b exp=%b", c + 1, m1_rvalid, (c == 4)); end
      if (c == 4) begin
        tests_run++; if (m1_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL starve_m1_rdata got=%h exp=deadbeef", m1_rdata); end
      end
    end
    idle();
  endtask

  task automatic test_out_of_range();
    drive_m1(1, 4'hF, 32'h3000, 32'h5555_5555);
    #2;
    tests_run++; if (dm_en !== 1'b0) begin tests_failed++; $display("FAIL oor_dm_en got=%b exp=0", dm_en); end
    tests_run++; if (m1_gnt !== 1'b1) begin tests_failed++; $display("FAIL oor_m1_gnt got=%b exp=1", m1_gnt); end
    tick(); idle();
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL oor_err_next got=%b exp=1", err); end
    tests_run++; if (m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL oor_store_rvalid got=%b exp=0", m1_rvalid); end
    tick();
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL oor_err_clear got=%b exp=0", err); end
  endtask

  task automatic test_m1_read();
    drive_m1(0, 4'hF, 32'h10, 32'h0);
    #2;
    tests_run++; if (m1_gnt !== 1'b1) begin tests_failed++; $display("FAIL m1rd_gnt got=%b exp=1", m1_gnt); end
    tests_run++; if (m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL m1rd_rvalid_early got=%b exp=0", m1_rvalid); end
    tick(); idle();
    tests_run++; if (m1_rvalid !== 1'b1) begin tests_failed++; $display("FAIL m1rd_rvalid got=%b exp=1", m1_rvalid); end
    tests_run++; if (m1_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL m1rd_rdata got=%h exp=deadbeef", m1_rdata); end
    tick();
    tests_run++; if (m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL m1rd_rvalid_once got=%b exp=0", m1_rvalid); end
  endtask

  task automatic test_reset_in_force();
    for (int c = 1; c <= 3; c++) begin
      drive_m0(0, 4'h0, 32'h10, 32'h0, 32'h600);
      drive_m1(1, 4'hF, 32'h40, 32'hCAFE_F00D);
      #2;
      tests_run++; if (m1_gnt !== 1'b0) begin tests_failed++; $display("FAIL rf_pre_gnt cyc=%0d got=%b exp=0", c, m1_gnt); end
      tick();
    end
    reset = 1;
    #2;
    tests_run++; if (m1_gnt !== 1'b0) begin tests_failed++; $display("FAIL rf_rst_gnt got=%b exp=0", m1_gnt); end
    tests_run++; if (dm_en !== 1'b0) begin tests_failed++; $display("FAIL rf_rst_dm_en got=%b exp=0", dm_en); end
    tick();
    reset = 0;
    for (int c = 1; c <= 4; c++) begin
      #2;
      tests_run++; if (m1_gnt !== (c == 4)) begin tests_failed++; $display("FAIL rf_post_gnt cyc=%0d got=%b exp=%b", c, m1_gnt, (c == 4)); end
      if (c == 4) begin
        tests_run++; if (dm_en !== 1'b1 || dm_wd !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL rf_post_write en=%b wd=%h exp en=1 wd=cafef00d", dm_en, dm_wd); end
        tests_run++; if (dm_pc !== 32'h0) begin tests_failed++; $display("FAIL rf_post_dm_pc got=%h exp=0", dm_pc); end
      end
      tick();
    end
    idle();
    drive_m1(0, 4'hF, 32'h40, 32'h0);
    tick(); idle();
    tests_run++; if (m1_rdata !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL rf_readback got=%h exp=cafef00d", m1_rdata); end
    tick();
  endtask

  task automatic test_random();
    int unsigned denied;
    logic        p1, p1_we, g0, g1, inr, en_e, we_s, exp_rv, exp_err;
    logic [3:0]  p1_be, be_s;
    logic [31:0] p1_addr, p1_wdata, a, wd_s, wd_e, exp_rd, old;
    logic [11:0] idx;
    p1 = 0; denied = 0;
    p1_we = 0; p1_be = 4'h0; p1_addr = 32'h0; p1_wdata = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1; p1_we = 1'($urandom_range(0, 1)); p1_be = 4'($urandom);
        p1_addr = rand_addr(); p1_wdata = $urandom;
      end
      m0_req = ($urandom_range(0, 3) != 0); m0_we = 1'($urandom_range(0, 1));
      m0_be = 4'($urandom); m0_addr = rand_addr(); m0_wdata = $urandom; m0_pc = $urandom;
      m1_req = p1; m1_we = p1_we; m1_be = p1_be; m1_addr = p1_addr; m1_wdata = p1_wdata;
      // Port 1 wins when the CPU is idle or after STARVE_MAX-1 consecutive denials.
      g1 = p1 && (!m0_req || denied >= STARVE_MAX - 1);
      g0 = m0_req && !g1;
      if (g1) begin a = p1_addr; we_s = p1_we; be_s = p1_be; wd_s = p1_wdata; end
      else    begin a = m0_addr; we_s = m0_we; be_s = m0_be; wd_s = m0_wdata; end
      inr  = a < DEPTH_WORDS * 4;
      idx  = a[13:2];
      old  = ref_mem[idx];
      en_e = (g0 || g1) && we_s && (be_s != 4'h0) && inr;
      wd_e = lane_merge(be_s, wd_s, old);
      #2;
      tests_run++; if (m1_gnt !== g1) begin tests_failed++; $display("FAIL rnd_m1_gnt n=%0d got=%b exp=%b", n, m1_gnt, g1); end
      tests_run++; if (m0_stall !== (m0_req && !g0)) begin tests_failed++; $display("FAIL rnd_m0_stall n=%0d got=%b exp=%b", n, m0_stall, m0_req && !g0); end
      tests_run++; if (dm_en !== en_e) begin tests_failed++; $display("FAIL rnd_dm_en n=%0d got=%b exp=%b", n, dm_en, en_e); end
      if (en_e) begin
        tests_run++;
        if (dm_addr !== a || dm_wd !== wd_e || dm_pc !== (g0 ? m0_pc : 32'h0)) begin
          tests_failed++;
          $display("FAIL rnd_write n=%0d got addr=%h wd=%h pc=%h exp addr=%h wd=%h pc=%h",
                   n, dm_addr, dm_wd, dm_pc, a, wd_e, g0 ? m0_pc : 32'h0);
        end
      end
      if (g0 && !m0_we) begin
        tests_run++; if (m0_rdata !== (inr ? old : 32'h0)) begin tests_failed++; $display("FAIL rnd_m0_rdata n=%0d got=%h exp=%h", n, m0_rdata, inr ? old : 32'h0); end
      end
      exp_rv  = g1 && !p1_we;
      exp_rd  = inr ? old : 32'h0;
      exp_err = (g0 || g1) && !inr;
      if (en_e) ref_mem[idx] = wd_e;
      if (g1) begin p1 = 0; denied = 0; end
      else if (p1 && m0_req) denied++;
      tick();
      tests_run++; if (m1_rvalid !== exp_rv) begin tests_failed++; $display("FAIL rnd_m1_rvalid n=%0d got=%b exp=%b", n, m1_rvalid, exp_rv); end
      if (exp_rv) begin
        tests_run++; if (m1_rdata !== exp_rd) begin tests_failed++; $display("FAIL rnd_m1_rdata n=%0d got=%h exp=%h", n, m1_rdata, exp_rd); end
      end
      tests_run++; if (err !== exp_err) begin tests_failed++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err, exp_err); end
    end
    idle();
  endtask

  initial begin
    reset = 1; idle();
    tick(); tick();
    test_reset();
    test_cpu_store();
    test_byte_merge();
    test_starvation();
    test_out_of_range();
    test_m1_read();
    test_reset_in_force();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
